// File: rtl/rk4_step_accumulator.sv
// rtl/rk4_step_accumulator.sv - RK4 step accumulator: y_next = y + floor((k1+2k2+2k3+k4)/6)
// Optional RK_SAT_EN: saturate y_out at 2^n-1 and raise ovf instead of wrapping.
module rk4_step_accumulator #(
  parameter int n     = 16,
  parameter int ACC_W = n + 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] y_in,
  input  logic [n-1:0] k_in,
  input  logic         k_valid,
  output logic         k_ready,
  output logic [n-1:0] y_out,
  output logic         done,
  output logic         busy,
  output logic         ovf
);

  localparam int CW = $clog2(ACC_W);
  localparam logic [CW-1:0] LAST_STEP = CW'(ACC_W - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;

  state_t           state_q;
  logic [n-1:0]     y_reg_q;
  logic [n-1:0]     y_out_q;
  logic [ACC_W-1:0] sum_q;
  logic [ACC_W-1:0] div_q;
  logic [2:0]       rem_q;
  logic [1:0]       k_idx_q;
  logic [CW-1:0]    cnt_q;
  logic             k_ready_q;
  logic             done_q;
  logic             busy_q;

  logic [ACC_W-1:0] k_ext;
  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] sum_d;
  logic [3:0]       rem_shift;
  logic             q_bit;
  logic [2:0]       rem_d;

  // k2 and k3 carry weight 2 in the RK4 combination
  always_comb begin
    k_ext  = ACC_W'(k_in);
    addend = k_ext;
    if (k_idx_q == 2'd1 || k_idx_q == 2'd2) begin
      addend = {k_ext[ACC_W-2:0], 1'b0};
    end
    sum_d = sum_q + addend;
  end

  // Remainder stays below 6, so a 3-bit register plus one shifted-in bit suffices
  always_comb begin
    rem_shift = {rem_q, div_q[ACC_W-1]};
    q_bit     = (rem_shift >= 4'd6);
    rem_d     = rem_shift[2:0];
    if (q_bit) begin
      rem_d = 3'(rem_shift - 4'd6);
    end
  end

`ifdef RK_SAT_EN
  logic         ovf_q;
  logic [n:0]   y_sum;
  assign y_sum = {1'b0, y_reg_q} + {1'b0, div_q[n-1:0]};
  assign ovf   = ovf_q;
`else
  logic [n-1:0] y_sum;
  assign y_sum = y_reg_q + div_q[n-1:0];
  assign ovf   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      y_reg_q   <= '0;
      y_out_q   <= '0;
      sum_q     <= '0;
      div_q     <= '0;
      rem_q     <= '0;
      k_idx_q   <= '0;
      cnt_q     <= '0;
      k_ready_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef RK_SAT_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef RK_SAT_EN
      ovf_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (start) begin
            y_reg_q   <= y_in;
            sum_q     <= '0;
            k_idx_q   <= '0;
            k_ready_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ACCUM;
          end
        end
        ACCUM: begin
          if (k_valid) begin
            sum_q   <= sum_d;
            k_idx_q <= k_idx_q + 2'd1;
            if (k_idx_q == 2'd3) begin
              div_q     <= sum_d;
              rem_q     <= '0;
              cnt_q     <= '0;
              k_ready_q <= 1'b0;
              state_q   <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          // Dividend shifts out MSB-first while quotient bits shift in at the bottom
          div_q <= {div_q[ACC_W-2:0], q_bit};
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state_q <= DONE;
          end
        end
        DONE: begin
`ifdef RK_SAT_EN
          if (y_sum[n]) begin
            y_out_q <= '1;
            ovf_q   <= 1'b1;
          end else begin
            y_out_q <= y_sum[n-1:0];
          end
`else
          y_out_q <= y_sum;
`endif
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign k_ready = k_ready_q;
  assign y_out   = y_out_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_rk4_step_accumulator.sv
// tb/tb_rk4_step_accumulator.sv - randomized self-checking bench for rk4_step_accumulator
module tb_rk4_step_accumulator;

  localparam int N = 16;
  localparam int LAT = (N + 3) + 2;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] y_in;
  logic [N-1:0] k_in;
  logic         k_valid;
  logic         k_ready;
  logic [N-1:0] y_out;
  logic         done;
  logic         busy;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  rk4_step_accumulator #(.n(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .y_in   (y_in),
    .k_in   (k_in),
    .k_valid(k_valid),
    .k_ready(k_ready),
    .y_out  (y_out),
    .done   (done),
    .busy   (busy),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the RK4 weighted sum
  function automatic logic [16:0] ref_step(input int y, input int k0, input int k1,
                                           input int k2, input int k3);
    int s;
    int r;
    s = k0 + 2 * k1 + 2 * k2 + k3;
    r = y + s / 6;
`ifdef RK_SAT_EN
    if (r > 65535) return {1'b1, 16'hffff};
`endif
    return {1'b0, 16'(r % 65536)};
  endfunction

  task automatic do_step(input string name, input int y, input int k0, input int k1,
                         input int k2, input int k3, input int gap, input bit noise,
                         input bit chain_next, input int chain_y, input bit skip_start);
    int kv[4];
    logic [16:0] exp;
    int done_cnt;
    int done_cyc;
    kv = '{k0, k1, k2, k3};
    exp = ref_step(y, k0, k1, k2, k3);
    if (!skip_start) begin
      @(negedge clk);
      checks++;
      if (k_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s idle_k_ready: got %0b expected 0", name, k_ready);
      end
      start = 1'b1; y_in = 16'(y); k_valid = 1'b1; k_in = 16'hbeef;
      @(negedge clk);
      start = 1'b0; k_valid = 1'b0;
    end
    checks++;
    if (busy !== 1'b1 || k_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accum_entry: got busy=%0b k_ready=%0b expected 1 1", name, busy, k_ready);
    end
    for (int i = 0; i < 4; i++) begin
      repeat (gap) begin
        k_valid = 1'b0; k_in = 16'($urandom); start = noise; y_in = 16'($urandom);
        @(negedge clk);
      end
      start = 1'b0; k_valid = 1'b1; k_in = 16'(kv[i]);
      @(negedge clk);
    end
    k_valid = 1'b0;
    done_cnt = 0;
    done_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 1) begin
        checks++;
        if (k_ready !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s divide_flags: got k_ready=%0b busy=%0b expected 0 1", name, k_ready, busy);
        end
      end
      if (noise) begin
        start = (c == 5);
        y_in = 16'($urandom);
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = c;
          checks++;
          if (y_out !== exp[15:0] || ovf !== exp[16]) begin
            errors++;
            $display("FAIL %s result: got y_out=%0d ovf=%0b expected %0d %0b",
                     name, y_out, ovf, exp[15:0], exp[16]);
          end
          if (chain_next) begin
            start = 1'b1; y_in = 16'(chain_y);
            @(negedge clk);
            start = 1'b0;
            break;
          end
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (done_cyc != LAT) begin
      errors++;
      $display("FAIL %s latency: got cycle %0d expected %0d", name, done_cyc, LAT);
    end
    if (!chain_next) begin
      checks++;
      if (done_cnt != 1 || busy !== 1'b0 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL %s done_once: got pulses=%0d busy=%0b ovf=%0b expected 1 0 0",
                 name, done_cnt, busy, ovf);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (y_out !== 16'd0 || done !== 1'b0 || busy !== 1'b0 || k_ready !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got y_out=%0d done=%0b busy=%0b k_ready=%0b ovf=%0b expected all 0",
               y_out, done, busy, k_ready, ovf);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    do_step("basic", 100, 6, 6, 6, 6, 0, 1'b0, 1'b0, 0, 1'b0);
    do_step("floor", 0, 5, 0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    do_step("exact", 0, 1, 1, 1, 1, 0, 1'b0, 1'b0, 0, 1'b0);
    do_step("overflow", 1, 65535, 65535, 65535, 65535, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_step("backpressure", 10, 12, 3, 3, 12, 3, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_step("start_ignored", 100, 6, 6, 6, 6, 2, 1'b1, 1'b1, 106, 1'b0);
    do_step("chained", 106, 6, 6, 6, 6, 0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    start = 1'b1; y_in = 16'd50;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      k_valid = 1'b1; k_in = 16'($urandom_range(1, 60000));
      @(negedge clk);
    end
    k_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (y_out !== 16'd0 || done !== 1'b0 || busy !== 1'b0 || k_ready !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got y_out=%0d done=%0b busy=%0b k_ready=%0b ovf=%0b expected all 0",
               y_out, done, busy, k_ready, ovf);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d active cycles expected 0", seen);
    end
    do_step("after_reset", 7, 6, 6, 6, 6, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      do_step("random", int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 65535)), int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), 1'b0, 0, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; y_in = '0; k_in = '0; k_valid = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
